// File: rtl/wrr_scheduler.sv
// Weighted round-robin scheduler: moves words from 4 show-ahead input FIFOs to
// their paired output FIFOs, granting each queue up to weight consecutive pops.
module wrr_scheduler #(
    parameter int unsigned FIFO_UNITS = 4,
    parameter int unsigned WORD_SIZE  = 10,
    parameter int unsigned WEIGHT_W   = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [FIFO_UNITS*WEIGHT_W-1:0]  weights,
    input  logic [FIFO_UNITS-1:0]           in_empty,
    input  logic [FIFO_UNITS-1:0]           out_almost_full,
    input  logic [FIFO_UNITS*WORD_SIZE-1:0] in_data,
    output logic [FIFO_UNITS-1:0]           pop,
    output logic [FIFO_UNITS-1:0]           push,
    output logic [WORD_SIZE-1:0]            data_out,
    output logic [1:0]                      grant_idx,
    output logic                            busy
);

    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_BURST = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [WEIGHT_W-1:0]     credit_q, credit_d;
    logic [FIFO_UNITS-1:0]   push_q, push_d;
    logic [WORD_SIZE-1:0]    data_q, data_d;

    logic [WEIGHT_W-1:0]     weight_a [FIFO_UNITS];
    logic [WORD_SIZE-1:0]    word_a   [FIFO_UNITS];
    logic [FIFO_UNITS-1:0]   eligible;
    logic                    found;
    logic [IDX_W-1:0]        pick;
    logic [IDX_W-1:0]        cand;
    logic                    pop_fire;

    // Unpack the flat weight and data buses and form per-queue eligibility
    always_comb begin
        for (int i = 0; i < FIFO_UNITS; i++) begin
            weight_a[i] = weights[i*WEIGHT_W +: WEIGHT_W];
            word_a[i]   = in_data[i*WORD_SIZE +: WORD_SIZE];
            eligible[i] = ~in_empty[i] & ~out_almost_full[i] & (weight_a[i] != '0);
        end
    end

    // First eligible queue at or after rr_ptr, wrapping modulo 4
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < FIFO_UNITS; k++) begin
            cand = rr_ptr_q + IDX_W'(k);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Pop is combinational so out_almost_full and in_empty act in the pop cycle
    always_comb begin
        pop      = '0;
        pop_fire = (state_q == S_BURST) & enable & (credit_q != '0) & eligible[grant_q];
        if (pop_fire) begin
            pop[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        credit_d = credit_q;
        push_d   = '0;
        data_d   = data_q;

        if (pop_fire) begin
            push_d = pop;
            data_d = word_a[grant_q];
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (found) begin
                    grant_d  = pick;
                    credit_d = weight_a[pick];
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                if (!enable) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = grant_q + IDX_W'(1);
                end else if (pop_fire) begin
                    credit_d = credit_q - WEIGHT_W'(1);
                    if (credit_q == WEIGHT_W'(1)) begin
                        state_d  = S_ARB;
                        rr_ptr_d = grant_q + IDX_W'(1);
                    end
                end else begin
                    // Stalled burst forfeits its remaining credit
                    state_d  = S_ARB;
                    rr_ptr_d = grant_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            credit_q <= '0;
            push_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            credit_q <= credit_d;
            push_q   <= push_d;
            data_q   <= data_d;
        end
    end

    assign push      = push_q;
    assign data_out  = data_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q != S_IDLE) | (|push_q);

endmodule
